// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter bus checker: FSM encoding,
// default widths and an all-ones constant helper.
package counter_checker_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned ERR_W_DEF = 16;

  // Lock-acquisition state machine encoding.
  typedef enum logic [1:0] {
    ST_ACQ     = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Returns a value with the low w bits set (w up to 64). Callers size-cast
  // the result to their own bus width.
  function automatic logic [63:0] all_ones(input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; optionally sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned W        = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment; increment stops at full scale.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(SATURATE && (&count_q))) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker for a free-running counter bus. Registers the bus,
// locks onto the count sequence, then flags value and rollover errors
// against a locally free-running prediction.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     q_in,
  input  logic             rollover_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             rollover_err,
  output logic             err_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     bad_value,
  output logic [N-1:0]     exp_value,
  output logic [7:0]       wraps
);

  localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(LOSS_CNT + 1);

  localparam logic [N-1:0]    ONES     = N'(all_ones(N));
  localparam logic [N-1:0]    ONE      = N'(1);
  localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] LOSS_TGT = MS_W'(LOSS_CNT);

  state_e          state_q,        state_d;
  logic [N-1:0]    q_r_q,          q_r_d;
  logic            ro_r_q,         ro_r_d;
  logic [N-1:0]    exp_q,          exp_d;
  logic [MC_W-1:0] match_cnt_q,    match_cnt_d;
  logic [MS_W-1:0] miss_cnt_q,     miss_cnt_d;
  logic            mismatch_q,     mismatch_d;
  logic            rollover_err_q, rollover_err_d;
  logic            err_seen_q,     err_seen_d;
  logic [N-1:0]    bad_value_q,    bad_value_d;
  logic [7:0]      wraps_q,        wraps_d;

  logic q_match;
  logic q_is_ones;
  logic err_d;

  // Next-state, prediction and check logic. Everything advances only on
  // enabled cycles; clr_err is a control-path clear and acts regardless.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    q_r_d          = q_r_q;
    ro_r_d         = ro_r_q;
    exp_d          = exp_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    mismatch_d     = 1'b0;
    rollover_err_d = 1'b0;
    bad_value_d    = bad_value_q;
    wraps_d        = wraps_q;

    q_match   = (q_r_q == exp_q);
    q_is_ones = (q_r_q == ONES);

    if (en) begin
      q_r_d  = q_in;
      ro_r_d = rollover_in;

      unique case (state_q)
        ST_ACQ: begin
          // Seed the prediction from whatever is on the bus.
          exp_d       = q_r_q + ONE;
          match_cnt_d = '0;
          state_d     = ST_LOCKING;
        end

        ST_LOCKING: begin
          // Re-seed every sample; count only unbroken runs of matches.
          exp_d = q_r_q + ONE;
          if (q_match) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
            if (match_cnt_d == LOCK_TGT) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        ST_LOCKED: begin
          // Prediction free-runs; a bad sample never re-seeds it.
          exp_d          = exp_q + ONE;
          rollover_err_d = (ro_r_q != q_is_ones);
          if (q_match) begin
            miss_cnt_d = '0;
            if (q_is_ones) wraps_d = wraps_q + 8'd1;
          end else begin
            mismatch_d  = 1'b1;
            bad_value_d = q_r_q;
            miss_cnt_d  = miss_cnt_q + MS_W'(1);
            if (miss_cnt_d == LOSS_TGT) state_d = ST_ACQ;
          end
        end

        default: state_d = ST_ACQ;
      endcase
    end

    err_d      = mismatch_d | rollover_err_d;
    err_seen_d = err_seen_q | err_d;
    if (clr_err) begin
      err_seen_d  = 1'b0;
      bad_value_d = '0;
    end
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ACQ;
      q_r_q          <= '0;
      ro_r_q         <= 1'b0;
      exp_q          <= '0;
      match_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      mismatch_q     <= 1'b0;
      rollover_err_q <= 1'b0;
      err_seen_q     <= 1'b0;
      bad_value_q    <= '0;
      wraps_q        <= '0;
    end else begin
      state_q        <= state_d;
      q_r_q          <= q_r_d;
      ro_r_q         <= ro_r_d;
      exp_q          <= exp_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      mismatch_q     <= mismatch_d;
      rollover_err_q <= rollover_err_d;
      err_seen_q     <= err_seen_d;
      bad_value_q    <= bad_value_d;
      wraps_q        <= wraps_d;
    end
  end

  // Error cycles counted once each, stuck at full scale.
  sat_counter #(
    .W        (ERR_W),
    .SATURATE (1'b1)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_d),
    .clr   (clr_err),
    .count (err_count)
  );

  assign locked       = (state_q == ST_LOCKED);
  assign mismatch     = mismatch_q;
  assign rollover_err = rollover_err_q;
  assign err_seen     = err_seen_q;
  assign bad_value    = bad_value_q;
  assign exp_value    = exp_q;
  assign wraps        = wraps_q;

endmodule
